// File: rtl/frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// frame_sequencer_if
//   Handshake and buffer-control bundle between the frame sequencer and the
//   input stream, the RGB pixel buffer, the colour-correction engine and the
//   output stream. Signal suffixes are named from the sequencer's viewpoint.
//   The sequencer connects through 'master'. The environment connects through
//   'slave'.
//
//   start_i      begin a frame (sampled only when idle)
//   in_valid_i   raw pixel present         in_ready_o    pixel accepted
//   buf_we_o     buffer write strobe       buf_waddr_o   buffer write address
//   proc_start_o engine start pulse        proc_done_i   engine finished
//   buf_re_o     buffer read strobe        buf_raddr_o   buffer read address
//   out_valid_o  output pixel valid        out_ready_i   downstream ready
//   out_last_o   last pixel of frame       busy_o        frame in progress
//   frame_done_o one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
interface frame_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              start_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              buf_we_o;
  logic [ADDR_W-1:0] buf_waddr_o;
  logic              proc_start_o;
  logic              proc_done_i;
  logic              buf_re_o;
  logic [ADDR_W-1:0] buf_raddr_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              out_last_o;
  logic              busy_o;
  logic              frame_done_o;

  modport master (
    input  start_i, in_valid_i, proc_done_i, out_ready_i,
    output in_ready_o, buf_we_o, buf_waddr_o, proc_start_o, buf_re_o,
           buf_raddr_o, out_valid_o, out_last_o, busy_o, frame_done_o
  );

  modport slave (
    output start_i, in_valid_i, proc_done_i, out_ready_i,
    input  in_ready_o, buf_we_o, buf_waddr_o, proc_start_o, buf_re_o,
           buf_raddr_o, out_valid_o, out_last_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//   Frame-level controller for the per-pixel RGB buffer. It runs one frame
//   through LOAD -> PROC -> UNLOAD and then returns to IDLE. It drives the
//   buffer write/read strobes and addresses. It handshakes one start/done pair
//   with the correction engine. It holds no pixel data.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous active-high reset; clears all state
//     bus   frame_sequencer_if.master (streams, buffer control, engine
//           handshake, status)
//
//   Parameters
//     PIXELS  pixels per frame, 1..2**ADDR_W
//     ADDR_W  buffer address width
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int PIXELS = 300,
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  frame_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_PROC   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] load_cnt_q, load_cnt_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  // Marks the first cycle of PROC or UNLOAD. The state qualifies which one.
  logic              entry_q, entry_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;

  logic              in_ready;
  logic              accept;
  logic              handshake;
  logic              last_out;
  logic              buf_re;
  logic [ADDR_W-1:0] buf_raddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      out_idx_q    <= '0;
      entry_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      out_idx_q    <= out_idx_d;
      entry_q      <= entry_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    out_idx_d    = out_idx_q;
    entry_d      = 1'b0;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    in_ready     = 1'b0;
    accept       = 1'b0;
    buf_re       = 1'b0;
    // The read address normally tracks the pixel being presented. It is held
    // during a stall because no new read is issued.
    buf_raddr    = out_idx_q;
    handshake    = out_valid_q & bus.out_ready_i;
    last_out     = out_valid_q & (out_idx_q == LAST_IDX);

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = S_LOAD;
      end

      S_LOAD: begin
        in_ready = 1'b1;
        accept   = bus.in_valid_i;
        if (accept) begin
          if (load_cnt_q == LAST_IDX) begin
            state_d    = S_PROC;
            load_cnt_d = '0;
            entry_d    = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q + ONE;
          end
        end
      end

      S_PROC: begin
        if (bus.proc_done_i) begin
          state_d = S_UNLOAD;
          entry_d = 1'b1;
        end
      end

      S_UNLOAD: begin
        // The first read (address 0) is issued on entry. Each later read is
        // issued in the same cycle as the handshake that frees the output
        // slot, which sustains one pixel per cycle.
        if (entry_q) buf_re = 1'b1;
        if (handshake) begin
          if (last_out) begin
            state_d      = S_IDLE;
            out_idx_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            buf_re    = 1'b1;
            buf_raddr = out_idx_q + ONE;
            out_idx_d = out_idx_q + ONE;
          end
        end
        // Read data is valid from the cycle after the read. It stays valid
        // until it is consumed.
        out_valid_d = buf_re | (out_valid_q & ~bus.out_ready_i);
      end

      default: begin
        state_d     = S_IDLE;
        load_cnt_d  = '0;
        out_idx_d   = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.buf_we_o     = accept;
  assign bus.buf_waddr_o  = load_cnt_q;
  assign bus.proc_start_o = (state_q == S_PROC) & entry_q;
  assign bus.buf_re_o     = buf_re;
  assign bus.buf_raddr_o  = buf_raddr;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_last_o   = last_out;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  localparam int AW = 9;
  localparam int OW = 26;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int sel;
  logic start, in_valid, proc_done, out_ready;
  logic [23:0] in_data;

  frame_sequencer_if #(.ADDR_W(AW)) if_a ();
  frame_sequencer_if #(.ADDR_W(AW)) if_b ();
  frame_sequencer_if #(.ADDR_W(AW)) if_c ();

  frame_sequencer #(.PIXELS(4),   .ADDR_W(AW)) dut_a (.clk(clk), .rst(rst), .bus(if_a.master));
  frame_sequencer #(.PIXELS(300), .ADDR_W(AW)) dut_b (.clk(clk), .rst(rst), .bus(if_b.master));
  frame_sequencer #(.PIXELS(1),   .ADDR_W(AW)) dut_c (.clk(clk), .rst(rst), .bus(if_c.master));

  // Only the selected instance sees Start. The other inputs are shared, and
  // the idle instances stay idle because they never receive Start.
  assign if_a.start_i = start && (sel == 0);
  assign if_b.start_i = start && (sel == 1);
  assign if_c.start_i = start && (sel == 2);
  assign if_a.in_valid_i = in_valid;  assign if_b.in_valid_i = in_valid;  assign if_c.in_valid_i = in_valid;
  assign if_a.proc_done_i = proc_done; assign if_b.proc_done_i = proc_done; assign if_c.proc_done_i = proc_done;
  assign if_a.out_ready_i = out_ready; assign if_b.out_ready_i = out_ready; assign if_c.out_ready_i = out_ready;

  logic [OW-1:0] vec_a, vec_b, vec_c, obs;
  assign vec_a = {if_a.in_ready_o, if_a.buf_we_o, if_a.buf_waddr_o, if_a.proc_start_o, if_a.buf_re_o,
                  if_a.buf_raddr_o, if_a.out_valid_o, if_a.out_last_o, if_a.busy_o, if_a.frame_done_o};
  assign vec_b = {if_b.in_ready_o, if_b.buf_we_o, if_b.buf_waddr_o, if_b.proc_start_o, if_b.buf_re_o,
                  if_b.buf_raddr_o, if_b.out_valid_o, if_b.out_last_o, if_b.busy_o, if_b.frame_done_o};
  assign vec_c = {if_c.in_ready_o, if_c.buf_we_o, if_c.buf_waddr_o, if_c.proc_start_o, if_c.buf_re_o,
                  if_c.buf_raddr_o, if_c.out_valid_o, if_c.out_last_o, if_c.busy_o, if_c.frame_done_o};
  assign obs = (sel == 0) ? vec_a : (sel == 1) ? vec_b : vec_c;

  logic o_in_ready, o_we, o_ps, o_re, o_ov, o_last, o_busy, o_fd;
  logic [AW-1:0] o_waddr, o_raddr;
  assign {o_in_ready, o_we, o_waddr, o_ps, o_re, o_raddr, o_ov, o_last, o_busy, o_fd} = obs;

  // Pixel buffer. Reads are registered, so data appears the cycle after a read.
  logic [23:0] mem [0:(1<<AW)-1];
  logic [23:0] rd_data;
  always @(posedge clk) begin
    if (o_we) mem[o_waddr] <= in_data;
    if (o_re) rd_data <= mem[o_raddr];
  end

  int errors = 0;
  int checks = 0;
  logic [23:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs `frames` frames on instance s. The reference model tracks the phase,
  // the accept count, the output index, the pending output and the entry cycle.
  // It computes every expected output from these values for each cycle.
  task automatic run(input int s, input int frames, input int vmode, input int rmode,
                     input int pd_delay, input int stall_at, input int abort_at, input bit noise);
    int n, ph, acc, oidx, pcnt, started, stall_left, cyc, pstarts, lasts;
    bit first, ov, fd, hs, lastk, e_re, aborted;
    logic [23:0] exp_px;
    n = (s == 0) ? 4 : (s == 1) ? 300 : 1;
    sel = s;
    ph = 0; acc = 0; oidx = 0; pcnt = 0; started = 0; stall_left = 3; cyc = 0;
    pstarts = 0; lasts = 0; first = 0; ov = 0; fd = 0; aborted = 0;
    sb.delete();
    while (cyc < 20000) begin
      @(negedge clk);
      if (ph == 0) start = (started < frames);
      else         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_valid  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      proc_done = (ph == 2) ? (pcnt == pd_delay) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) begin
        if (ph == 3 && ov && oidx == stall_at && stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else out_ready = 1'b1;
      end else out_ready = 1'($urandom_range(0, 1));
      in_data = 24'($urandom);
      #1;
      if (abort_at >= 0 && ph == 3 && ov && oidx == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_outputs_zero", 32'(obs), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        aborted = 1;
        break;
      end
      hs = ov && out_ready;
      lastk = (oidx == n - 1);
      e_re = (ph == 3) && (first || (hs && !lastk));
      check("busy",       32'(o_busy),     32'(ph != 0));
      check("in_ready",   32'(o_in_ready), 32'(ph == 1));
      check("buf_we",     32'(o_we),       32'(ph == 1 && in_valid));
      check("buf_waddr",  32'(o_waddr),    32'(acc));
      check("proc_start", 32'(o_ps),       32'(ph == 2 && first));
      check("buf_re",     32'(o_re),       32'(e_re));
      check("buf_raddr",  32'(o_raddr),    32'((ph == 3 && hs && !lastk) ? oidx + 1 : oidx));
      check("out_valid",  32'(o_ov),       32'(ov));
      check("out_last",   32'(o_last),     32'(ov && lastk));
      check("frame_done", 32'(o_fd),       32'(fd));
      if (o_ps) pstarts++;
      if (ph == 1 && in_valid) sb.push_back(in_data);
      if (hs && ph == 3) begin
        exp_px = (sb.size() > 0) ? sb.pop_front() : 24'hx;
        check("pixel_data", 32'(rd_data), 32'(exp_px));
        if (o_last) lasts++;
      end
      fd = (ph == 3) && hs && lastk;
      case (ph)
        0: if (start) begin ph = 1; started++; end
        1: if (in_valid) begin
             if (acc == n - 1) begin ph = 2; acc = 0; first = 1; pcnt = 0; end
             else acc++;
           end
        2: begin
             first = 0;
             if (proc_done) begin ph = 3; first = 1; end
             else pcnt++;
           end
        default: begin
             first = 0;
             if (hs && lastk) begin ph = 0; oidx = 0; ov = 0; end
             else begin
               if (hs) oidx++;
               ov = e_re || (ov && !out_ready);
             end
           end
      endcase
      cyc++;
      if (started >= frames && ph == 0 && !fd) break;
    end
    start = 1'b0;
    check("no_timeout", 32'(cyc < 20000), 32'd1);
    if (!aborted) begin
      check("proc_start_count", 32'(pstarts), 32'(frames));
      check("out_last_count", 32'(lasts), 32'(frames));
      check("all_pixels_out", 32'(sb.size()), 32'd0);
    end
    $display("run inst=%0d frames=%0d vmode=%0d rmode=%0d cycles=%0d errors=%0d", s, frames, vmode, rmode, cyc, errors);
  endtask

  initial begin
    rst = 1'b1; sel = 0; start = 0; in_valid = 0; proc_done = 0; out_ready = 0; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_a", 32'(vec_a), 32'd0);
    check("reset_b", 32'(vec_b), 32'd0);
    check("reset_c", 32'(vec_c), 32'd0);
    rst = 1'b0;
    run(0, 1, 0, 0, 3, -1, -1, 0);   // streaming frame, ProcDone 3 cycles after ProcStart
    run(0, 1, 1, 0, 2, -1, -1, 0);   // InValid toggling
    run(0, 1, 0, 1, 1, 1, -1, 0);    // 3-cycle stall at pixel 1
    run(0, 1, 0, 0, 2, -1, 2, 0);    // reset during UNLOAD at pixel 2
    run(0, 1, 0, 0, 2, -1, -1, 0);   // clean frame after abort
    run(0, 2, 2, 2, 0, -1, -1, 1);   // stray Start/ProcDone, ProcDone in first PROC cycle, back-to-back
    run(2, 2, 2, 2, 1, -1, -1, 1);   // PIXELS=1
    run(1, 1, 2, 2, 5, -1, -1, 1);   // PIXELS=300 random handshakes
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
